// File: rtl/noc_flit_pkg.sv
// Shared flit definitions for the NoC local injection path.
// Provides flit width, flit type codes, the fixed VC field, packet class
// codes, header field positions and flit-building helpers.
package noc_flit_pkg;

  localparam int FLIT_W = 38;

  typedef enum logic [1:0] {
    FLIT_BODY = 2'b00,
    FLIT_TAIL = 2'b01,
    FLIT_HEAD = 2'b10
  } flit_type_t;

  localparam logic [3:0] VC_DEFAULT = 4'b0001;

  typedef enum logic [2:0] {
    CLS_SPIKE     = 3'b000,
    CLS_BIAS      = 3'b001,
    CLS_POTENTIAL = 3'b010,
    CLS_HISTORY   = 3'b011,
    CLS_CFG_A     = 3'b100
  } pkt_class_t;

  // Header field LSB positions; coordinates occupy 6-bit fields.
  localparam int TYPE_LSB  = 36;
  localparam int VC_LSB    = 32;
  localparam int CLASS_LSB = 29;
  localparam int DST_X_LSB = 18;
  localparam int DST_Y_LSB = 12;
  localparam int SRC_X_LSB = 6;
  localparam int SRC_Y_LSB = 0;
  localparam int COORD_W   = 6;

  function automatic logic [FLIT_W-1:0] make_header(
    input logic [2:0] cls,
    input logic [2:0] dx,
    input logic [2:0] dy,
    input logic [2:0] sx,
    input logic [2:0] sy
  );
    logic [FLIT_W-1:0] h;
    h = '0;
    h[TYPE_LSB +: 2]        = FLIT_HEAD;
    h[VC_LSB +: 4]          = VC_DEFAULT;
    h[CLASS_LSB +: 3]       = cls;
    h[DST_X_LSB +: COORD_W] = COORD_W'(dx);
    h[DST_Y_LSB +: COORD_W] = COORD_W'(dy);
    h[SRC_X_LSB +: COORD_W] = COORD_W'(sx);
    h[SRC_Y_LSB +: COORD_W] = COORD_W'(sy);
    return h;
  endfunction

  function automatic logic [FLIT_W-1:0] make_data(
    input logic        last,
    input logic [31:0] word
  );
    logic [1:0] t;
    t = last ? FLIT_TAIL : FLIT_BODY;
    return {t, VC_DEFAULT, word};
  endfunction

endpackage

// File: rtl/local_inject_scheduler_credit_counter.sv
// Credit counter tracking free slots in the router local input buffer.
// Ports: clk, reset (sync, active-high); inc (credit returned), dec (flit
// written); count (free slots), nonzero (count > 0), err (sticky overflow).
module credit_counter #(
  parameter int BUF_DEPTH = 4,
  parameter int CNT_W     = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             nonzero,
  output logic             err
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(BUF_DEPTH);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= FULL;
      err   <= 1'b0;
    end else if (inc && !dec) begin
      // A credit with no outstanding flit saturates and flags the overflow.
      if (count == FULL) err <= 1'b1;
      else               count <= count + 1'b1;
    end else if (dec && !inc) begin
      count <= count - 1'b1;
    end
  end

  assign nonzero = (count != '0);

endmodule

// File: rtl/local_inject_scheduler.sv
// Local-port injection scheduler: round-robin between the spike generator
// and the config engine at packet boundaries, builds head/body/tail flits
// and paces writes with a credit counter.
// Ports: clk, reset (sync, active-high); current_x/y (source coords);
// spk_* and cfg_* valid/ready request interfaces; credit_in (slot freed);
// flit_out/flit_out_wr (registered flit write); busy (not idle);
// credit_err (sticky credit overflow).
module local_inject_scheduler #(
  parameter int FLIT_W    = noc_flit_pkg::FLIT_W,
  parameter int BUF_DEPTH = 4,
  parameter int CNT_W     = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        current_x,
  input  logic [2:0]        current_y,
  input  logic              spk_valid,
  output logic              spk_ready,
  input  logic [2:0]        spk_dst_x,
  input  logic [2:0]        spk_dst_y,
  input  logic [31:0]       spk_word,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [2:0]        cfg_dst_x,
  input  logic [2:0]        cfg_dst_y,
  input  logic [2:0]        cfg_class,
  input  logic [31:0]       cfg_word,
  input  logic              cfg_last,
  input  logic              credit_in,
  output logic [FLIT_W-1:0] flit_out,
  output logic              flit_out_wr,
  output logic              busy,
  output logic              credit_err
);

  import noc_flit_pkg::*;

  typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;
  typedef enum logic {REQ_SPK, REQ_CFG} req_t;

  state_t            state, state_d;
  req_t              grant, grant_d;
  req_t              prio, prio_d;
  logic [2:0]        dst_x, dst_y, cls, src_x, src_y;
  logic              latch;
  logic [FLIT_W-1:0] flit_d;
  logic              wr_d;
  logic [CNT_W-1:0]  credit;
  logic              credit_ok;

  credit_counter #(.BUF_DEPTH(BUF_DEPTH), .CNT_W(CNT_W)) u_credit (
    .clk     (clk),
    .reset   (reset),
    .inc     (credit_in),
    .dec     (wr_d),
    .count   (credit),
    .nonzero (credit_ok),
    .err     (credit_err)
  );

  credit_bound: assert property (@(posedge clk) disable iff (reset)
    credit <= CNT_W'(BUF_DEPTH));

  always_comb begin
    state_d   = state;
    grant_d   = grant;
    prio_d    = prio;
    latch     = 1'b0;
    flit_d    = flit_out;
    wr_d      = 1'b0;
    spk_ready = 1'b0;
    cfg_ready = 1'b0;
    unique case (state)
      IDLE: begin
        if (spk_valid || cfg_valid) begin
          grant_d = (spk_valid && (!cfg_valid || prio == REQ_SPK)) ? REQ_SPK : REQ_CFG;
          latch   = 1'b1;
          state_d = HEAD;
        end
      end
      HEAD: begin
        if (credit_ok) begin
          flit_d  = make_header(cls, dst_x, dst_y, src_x, src_y);
          wr_d    = 1'b1;
          state_d = BODY;
        end
      end
      BODY: begin
        if (grant == REQ_SPK) begin
          if (spk_valid && credit_ok) begin
            spk_ready = 1'b1;
            flit_d    = make_data(1'b1, spk_word);
            wr_d      = 1'b1;
            state_d   = IDLE;
            prio_d    = REQ_CFG;
          end
        end else if (cfg_valid && credit_ok) begin
          cfg_ready = 1'b1;
          flit_d    = make_data(cfg_last, cfg_word);
          wr_d      = 1'b1;
          if (cfg_last) begin
            state_d = IDLE;
            prio_d  = REQ_SPK;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= REQ_SPK;
      prio        <= REQ_SPK;
      dst_x       <= '0;
      dst_y       <= '0;
      cls         <= '0;
      src_x       <= '0;
      src_y       <= '0;
      flit_out    <= '0;
      flit_out_wr <= 1'b0;
    end else begin
      state       <= state_d;
      grant       <= grant_d;
      prio        <= prio_d;
      flit_out    <= flit_d;
      flit_out_wr <= wr_d;
      if (latch) begin
        dst_x <= (grant_d == REQ_SPK) ? spk_dst_x : cfg_dst_x;
        dst_y <= (grant_d == REQ_SPK) ? spk_dst_y : cfg_dst_y;
        cls   <= (grant_d == REQ_SPK) ? CLS_SPIKE : cfg_class;
        src_x <= current_x;
        src_y <= current_y;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_local_inject_scheduler.sv
module tb_local_inject_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  current_x, current_y;
  logic        spk_valid, spk_ready;
  logic [2:0]  spk_dst_x, spk_dst_y;
  logic [31:0] spk_word;
  logic        cfg_valid, cfg_ready;
  logic [2:0]  cfg_dst_x, cfg_dst_y, cfg_class;
  logic [31:0] cfg_word;
  logic        cfg_last;
  logic        credit_in;
  logic [37:0] flit_out;
  logic        flit_out_wr, busy, credit_err;

  always #5 clk = ~clk;

  local_inject_scheduler #(.FLIT_W(38), .BUF_DEPTH(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .current_x(current_x), .current_y(current_y),
    .spk_valid(spk_valid), .spk_ready(spk_ready), .spk_dst_x(spk_dst_x),
    .spk_dst_y(spk_dst_y), .spk_word(spk_word),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_dst_x(cfg_dst_x),
    .cfg_dst_y(cfg_dst_y), .cfg_class(cfg_class), .cfg_word(cfg_word),
    .cfg_last(cfg_last), .credit_in(credit_in), .flit_out(flit_out),
    .flit_out_wr(flit_out_wr), .busy(busy), .credit_err(credit_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- sources ----------------
  typedef struct packed {logic [2:0] dx; logic [2:0] dy; logic [31:0] w;} spk_t;
  typedef struct packed {logic [2:0] dx; logic [2:0] dy; logic [2:0] cls; logic [31:0] w; logic last;} cfg_t;
  spk_t spk_q[$];
  cfg_t cfg_q[$];
  bit   gaps = 0, auto_cr = 0, spk_hs = 0, cfg_hs = 0;
  int   occ = 0;

  initial begin
    spk_valid = 0; spk_dst_x = 0; spk_dst_y = 0; spk_word = 0;
    cfg_valid = 0; cfg_dst_x = 0; cfg_dst_y = 0; cfg_class = 0; cfg_word = 0; cfg_last = 0;
    forever begin
      @(posedge clk); #1;
      if (spk_hs && spk_q.size() > 0) void'(spk_q.pop_front());
      if (cfg_hs && cfg_q.size() > 0) void'(cfg_q.pop_front());
      spk_hs = 0; cfg_hs = 0;
      if (spk_q.size() > 0) begin
        spk_valid = !(gaps && $urandom_range(0, 4) == 0);
        spk_dst_x = spk_q[0].dx; spk_dst_y = spk_q[0].dy; spk_word = spk_q[0].w;
      end else spk_valid = 0;
      if (cfg_q.size() > 0) begin
        cfg_valid = !(gaps && $urandom_range(0, 4) == 0);
        cfg_dst_x = cfg_q[0].dx; cfg_dst_y = cfg_q[0].dy; cfg_class = cfg_q[0].cls;
        cfg_word = cfg_q[0].w; cfg_last = cfg_q[0].last;
      end else cfg_valid = 0;
      // Router stand-in: each written flit is drained and returned as a credit later.
      if (auto_cr) begin
        occ += int'(flit_out_wr);
        credit_in = 0;
        if (occ > 0 && $urandom_range(0, 1) == 1) begin
          credit_in = 1;
          occ--;
        end
      end
    end
  end

  // ---------------- reference model ----------------
  int          m_owner = -1;   // -1 none, 0 spike, 1 config
  bit          m_hdr = 0, m_err = 0, m_pref_cfg = 0, m_wr = 0, m_w = 0, started = 0;
  int          m_credit = 4;
  logic [37:0] m_flit = '0;
  logic [2:0]  m_dx, m_dy, m_cls, m_sx, m_sy;

  function automatic logic [37:0] hdr_of(input int cls, input int dx, input int dy, input int sx, input int sy);
    logic [63:0] v;
    v = (64'd2 << 36) + (64'd1 << 32) + (64'(cls) << 29) + (64'(dx) << 18)
      + (64'(dy) << 12) + (64'(sx) << 6) + 64'(sy);
    return v[37:0];
  endfunction

  function automatic logic [37:0] data_of(input bit last, input logic [31:0] w);
    logic [63:0] v;
    v = (last ? (64'd1 << 36) : 64'd0) + (64'd1 << 32) + 64'(w);
    return v[37:0];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_owner = -1; m_hdr = 0; m_credit = 4; m_err = 0; m_pref_cfg = 0; m_flit = '0; m_wr = 0;
    end else begin
      m_w = 0;
      if (m_owner < 0) begin
        if (spk_valid || cfg_valid) begin
          m_owner = (spk_valid && (!cfg_valid || !m_pref_cfg)) ? 0 : 1;
          m_hdr = 0; m_sx = current_x; m_sy = current_y;
          if (m_owner == 0) begin m_dx = spk_dst_x; m_dy = spk_dst_y; m_cls = 3'd0; end
          else begin m_dx = cfg_dst_x; m_dy = cfg_dst_y; m_cls = cfg_class; end
        end
      end else if (!m_hdr) begin
        if (m_credit > 0) begin
          m_flit = hdr_of(int'(m_cls), int'(m_dx), int'(m_dy), int'(m_sx), int'(m_sy));
          m_w = 1; m_hdr = 1;
        end
      end else if (m_owner == 0) begin
        if (spk_valid && m_credit > 0) begin
          m_flit = data_of(1'b1, spk_word); m_w = 1; m_owner = -1; m_pref_cfg = 1;
        end
      end else if (cfg_valid && m_credit > 0) begin
        m_flit = data_of(cfg_last, cfg_word); m_w = 1;
        if (cfg_last) begin m_owner = -1; m_pref_cfg = 0; end
      end
      if (credit_in && !m_w) begin
        if (m_credit == 4) m_err = 1;
        else m_credit++;
      end else if (m_w && !credit_in) m_credit--;
      m_wr = m_w;
    end
    started = 1;
  end

  // ---------------- compare + monitor ----------------
  int         wr_count = 0, spk_rdy_cnt = 0, interleave = 0, orphan = 0;
  bit         in_pkt = 0;
  logic [2:0] head_log[$];

  always @(negedge clk) begin
    if (started) begin
      check("flit_out", flit_out, m_flit);
      check("flit_out_wr", flit_out_wr, m_wr);
      check("busy", busy, m_owner >= 0);
      check("credit_err", credit_err, m_err);
      check("credit", dut.u_credit.count, 64'(m_credit));
      check("spk_ready", spk_ready, (m_owner == 0 && m_hdr && spk_valid && m_credit > 0));
      check("cfg_ready", cfg_ready, (m_owner == 1 && m_hdr && cfg_valid && m_credit > 0));
      spk_hs = spk_ready && !reset;
      cfg_hs = cfg_ready && !reset;
      if (spk_ready) spk_rdy_cnt++;
      if (flit_out_wr) begin
        wr_count++;
        if (flit_out[37:36] == 2'b10) begin
          if (in_pkt) interleave++;
          in_pkt = 1;
          head_log.push_back(flit_out[31:29]);
        end else begin
          if (!in_pkt) orphan++;
          if (flit_out[37:36] == 2'b01) in_pkt = 0;
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_wr(input int target, input int budget, input string name);
    int k = 0;
    while (wr_count < target && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    check(name, wr_count >= target, 1'b1);
  endtask

  // Called at negedge+1; holds reset across exactly one rising edge.
  task automatic do_reset(input bit chk, input string name);
    #1;
    reset = 1;
    spk_q.delete(); cfg_q.delete();
    spk_valid = 0; cfg_valid = 0; spk_hs = 0; cfg_hs = 0;
    credit_in = 0; occ = 0; in_pkt = 0;
    @(negedge clk); #1;
    if (chk) begin
      check({name, "_wr"}, flit_out_wr, 1'b0);
      check({name, "_flit"}, flit_out, 38'd0);
      check({name, "_busy"}, busy, 1'b0);
      check({name, "_credit"}, dut.u_credit.count, 3'd4);
      check({name, "_err"}, credit_err, 1'b0);
    end
    #1 reset = 0;
    @(negedge clk); #1;
  endtask

  task automatic push_cfg(input int n, input int cls, input int dx, input int dy, input logic [31:0] base);
    cfg_t c;
    for (int i = 0; i < n; i++) begin
      c.dx = 3'(dx); c.dy = 3'(dy); c.cls = 3'(cls); c.w = base + 32'(i); c.last = (i == n - 1);
      cfg_q.push_back(c);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   base;
    spk_t s;
    reset = 1; current_x = 3'd1; current_y = 3'd1; credit_in = 0;
    repeat (2) @(negedge clk);
    #1;
    do_reset(1'b1, "reset");

    // Test 1: single spike, idle router
    base = wr_count;
    spk_q.push_back('{3'd1, 3'd2, 32'h0000_0307});
    wait_wr(base + 1, 10, "t1_head_wait");
    check("t1_header", flit_out, {2'b10, 4'b0001, 3'b000, 5'b0, 6'd1, 6'd2, 6'd1, 6'd1});
    check("t1_ready", spk_ready, 1'b1);
    base = spk_rdy_cnt;
    @(negedge clk); #1;
    check("t1_tail_wr", flit_out_wr, 1'b1);
    check("t1_tail", flit_out, {2'b01, 4'b0001, 32'h0000_0307});
    repeat (4) @(negedge clk); #1;
    check("t1_ready_once", spk_rdy_cnt - base, 0);
    check("t1_idle", busy, 1'b0);

    // Test 2: 3-word config, class 010, no credit returns
    do_reset(1'b0, "");
    base = wr_count;
    push_cfg(3, 2, 3, 4, 32'hA000_0001);
    wait_wr(base + 1, 10, "t2_head_wait");
    check("t2_header", flit_out, {2'b10, 4'b0001, 3'b010, 5'b0, 6'd3, 6'd4, 6'd1, 6'd1});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("t2_wr_consecutive", flit_out_wr, 1'b1);
      check("t2_type", flit_out[37:36], (i == 2) ? 2'b01 : 2'b00);
      check("t2_word", flit_out[31:0], 32'hA000_0001 + 32'(i));
    end
    check("t2_credit0", dut.u_credit.count, 3'd0);

    // Test 3: both requesters continuously valid
    do_reset(1'b0, "");
    auto_cr = 1;
    head_log.delete();
    base = wr_count;
    for (int i = 0; i < 3; i++) spk_q.push_back('{3'(i), 3'(i + 1), 32'h5000_0000 + 32'(i)});
    push_cfg(2, 1, 2, 2, 32'hC100_0000);
    push_cfg(2, 4, 3, 3, 32'hC400_0000);
    wait_wr(base + 12, 200, "t3_drain");
    check("t3_npkts", head_log.size(), 5);
    if (head_log.size() >= 5) begin
      check("t3_order0", head_log[0], 3'd0);
      check("t3_order1", head_log[1], 3'd1);
      check("t3_order2", head_log[2], 3'd0);
      check("t3_order3", head_log[3], 3'd4);
      check("t3_order4", head_log[4], 3'd0);
    end

    // Tests 4/5: 6-word config with no credit returns, then paced release
    do_reset(1'b0, "");
    auto_cr = 0;
    base = wr_count;
    push_cfg(6, 3, 7, 0, 32'hD000_0000);
    wait_wr(base + 4, 20, "t4_first4");
    repeat (6) @(negedge clk); #1;
    check("t4_stall_count", wr_count - base, 4);
    check("t4_stall_busy", busy, 1'b1);
    check("t4_stall_ready", cfg_ready, 1'b0);
    credit_in = 1;                  // two consecutive credit pulses
    @(negedge clk); #2;
    @(negedge clk); #1;
    check("t5_write_with_credit", flit_out_wr, 1'b1);
    check("t5_credit_stays1", dut.u_credit.count, 3'd1);
    #1 credit_in = 0;
    repeat (5) @(negedge clk); #1;
    check("t4_release2", wr_count - base, 6);
    check("t4_still_busy", busy, 1'b1);
    credit_in = 1;
    @(negedge clk); #2 credit_in = 0;
    repeat (3) @(negedge clk); #1;
    check("t4_tail_done", wr_count - base, 7);
    check("t4_idle", busy, 1'b0);
    credit_in = 1;
    repeat (4) begin @(negedge clk); #2; end
    credit_in = 0;
    @(negedge clk); #1;
    check("t5_full_credit", dut.u_credit.count, 3'd4);
    check("t5_no_err_yet", credit_err, 1'b0);
    credit_in = 1;
    @(negedge clk); #2 credit_in = 0;
    @(negedge clk); #1;
    check("t5_overflow_err", credit_err, 1'b1);
    check("t5_saturated", dut.u_credit.count, 3'd4);

    // Test 6: reset mid-config, then a clean spike
    auto_cr = 1;
    base = wr_count;
    push_cfg(5, 1, 2, 5, 32'hE000_0000);
    wait_wr(base + 2, 30, "t6_mid_wait");
    check("t6_in_body", busy, 1'b1);
    do_reset(1'b1, "t6_reset");
    current_x = 3'd4; current_y = 3'd3;
    base = wr_count;
    spk_q.push_back('{3'd5, 3'd6, 32'hDEAD_BEEF});
    wait_wr(base + 1, 30, "t6_head_wait");
    check("t6_header", flit_out, {2'b10, 4'b0001, 3'b000, 5'b0, 6'd5, 6'd6, 6'd4, 6'd3});
    wait_wr(base + 2, 30, "t6_tail_wait");
    check("t6_tail", flit_out, {2'b01, 4'b0001, 32'hDEAD_BEEF});

    // Randomized traffic with bubbles and paced credits
    gaps = 1;
    for (int p = 0; p < 80; p++) begin
      if ($urandom_range(0, 1) == 1) begin
        s.dx = 3'($urandom_range(0, 7)); s.dy = 3'($urandom_range(0, 7)); s.w = $urandom();
        spk_q.push_back(s);
      end else begin
        push_cfg(int'($urandom_range(1, 5)), int'($urandom_range(1, 4)),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), $urandom());
      end
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk); #1;
        current_x = 3'($urandom_range(0, 7)); current_y = 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 8)) @(negedge clk);
      #1;
    end
    begin
      int k = 0;
      while ((spk_q.size() > 0 || cfg_q.size() > 0 || busy) && k < 5000) begin
        @(negedge clk); #1;
        k++;
      end
      check("rand_drain", k < 5000, 1'b1);
    end
    check("no_interleave", interleave, 0);
    check("no_orphan_flits", orphan, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
